// File: rtl/array_ctrl_pkg.sv
// Shared definitions for the systolic-array instruction controller:
// opcodes, FSM state encoding and instruction field positions.
package array_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_LOAD_W  = 4'd1,
    OP_LOAD_A  = 4'd2,
    OP_COMPUTE = 4'd3,
    OP_STORE   = 4'd4,
    OP_HALT    = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DRAIN,
    S_HALT
  } state_e;

  localparam int OP_MSB   = 63;
  localparam int OP_LSB   = 60;
  localparam int BASE_LSB = 32;
  localparam int LEN_MSB  = 15;
  localparam int LEN_LSB  = 0;

  // Opcodes that sequence the array through one or more beats.
  function automatic logic is_beat_op(input logic [3:0] op);
    return op inside {OP_LOAD_W, OP_LOAD_A, OP_COMPUTE, OP_STORE};
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_beat_op(op) || op == OP_NOP || op == OP_HALT;
  endfunction

endpackage

// File: rtl/ctrl_beat_counter.sv
// Loadable beat down-counter with stall hold, plus base+index address
// generator that wraps modulo 2^ADDR_WIDTH.
module ctrl_beat_counter #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [CNT_WIDTH-1:0]  load_len,
  input  logic [ADDR_WIDTH-1:0] load_base,
  output logic                  last_beat,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [CNT_WIDTH-1:0] cnt;

  // NOTE: every register here is reset in the async branch and updated only
  // with <=, so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      addr <= '0;
    end else if (load) begin
      cnt  <= load_len;
      addr <= load_base;
    end else if (step) begin
      cnt  <= cnt - 1'b1;
      addr <= addr + 1'b1;
    end
  end

  assign last_beat = (cnt == CNT_WIDTH'(1));

endmodule

// File: rtl/array_instr_controller.sv
// Pops 64-bit instructions over valid/ready and sequences the systolic array
// through load, compute (with pipeline drain) and store beats.
module array_instr_controller
  import array_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int ARRAY_DIM  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           instr_data,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic                  array_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic                  array_load_w,
  output logic                  array_load_a,
  output logic                  array_compute,
  output logic                  busy,
  output logic                  halted,
  output logic                  err_illegal
);

  localparam logic [CNT_WIDTH-1:0] DRAIN_LEN = CNT_WIDTH'(2 * ARRAY_DIM - 1);

  state_e                state;
  logic [3:0]            op;
  logic [3:0]            in_op;
  logic [CNT_WIDTH-1:0]  in_len;
  logic                  accept, start, step, last_beat, drain_load, cnt_load;
  logic [CNT_WIDTH-1:0]  load_len;
  logic [ADDR_WIDTH-1:0] load_base, beat_addr;
  logic                  unused_bits;

  assign in_op  = instr_data[OP_MSB:OP_LSB];
  assign in_len = CNT_WIDTH'(instr_data[LEN_MSB:LEN_LSB]);
  assign unused_bits = ^{instr_data[59:48], instr_data[31:16]};

  assign accept     = instr_valid && instr_ready;
  assign start      = accept && is_beat_op(in_op) && in_len != '0;
  assign step       = !array_stall && (state == S_EXEC || state == S_DRAIN);
  assign drain_load = state == S_EXEC && step && last_beat && op == OP_COMPUTE;

  // The counter is reused for the drain phase; the address simply holds.
  assign cnt_load  = start || drain_load;
  assign load_len  = start ? in_len : DRAIN_LEN;
  assign load_base = start ? instr_data[BASE_LSB +: ADDR_WIDTH] : beat_addr;

  ctrl_beat_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_beat_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .step      (step),
    .load_len  (load_len),
    .load_base (load_base),
    .last_beat (last_beat),
    .addr      (beat_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      op          <= OP_NOP;
      instr_ready <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          instr_ready <= 1'b1;
          if (accept) begin
            op <= in_op;
            if (!is_legal(in_op)) err_illegal <= 1'b1;
            if (in_op == OP_HALT) begin
              state       <= S_HALT;
              instr_ready <= 1'b0;
              busy        <= 1'b1;
              halted      <= 1'b1;
            end else if (start) begin
              state       <= S_EXEC;
              instr_ready <= 1'b0;
              busy        <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (step && last_beat) begin
            if (op == OP_COMPUTE) begin
              state <= S_DRAIN;
            end else begin
              state       <= S_IDLE;
              instr_ready <= 1'b1;
              busy        <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (step && last_beat) begin
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: ;  // S_HALT is left only through reset
      endcase
    end
  end

  // Strobes decode straight from registered state so reset drops them at once.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    mem_rd_en     = 1'b0;
    mem_wr_en     = 1'b0;
    array_load_w  = 1'b0;
    array_load_a  = 1'b0;
    array_compute = 1'b0;
    if (state == S_EXEC && !array_stall) begin
      case (op)
        OP_LOAD_W:  begin mem_rd_en = 1'b1; array_load_w = 1'b1; end
        OP_LOAD_A:  begin mem_rd_en = 1'b1; array_load_a = 1'b1; end
        OP_COMPUTE: array_compute = 1'b1;
        OP_STORE:   mem_wr_en = 1'b1;
        default:    ;
      endcase
    end else if (state == S_DRAIN && !array_stall) begin
      array_compute = 1'b1;
    end
  end

  assign mem_addr = beat_addr;

endmodule

// File: tb/tb_array_instr_controller.sv
// Directed bench for array_instr_controller: handshake, beat sequencing,
// drain length, stall hold, address wrap, illegal opcodes, HALT and reset.
module tb_array_instr_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] instr_data = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        array_stall = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd_en, mem_wr_en, array_load_w, array_load_a, array_compute;
  logic        busy, halted, err_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  array_instr_controller dut (
    .clk           (clk),
    .rst           (rst),
    .instr_data    (instr_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .array_stall   (array_stall),
    .mem_addr      (mem_addr),
    .mem_rd_en     (mem_rd_en),
    .mem_wr_en     (mem_wr_en),
    .array_load_w  (array_load_w),
    .array_load_a  (array_load_a),
    .array_compute (array_compute),
    .busy          (busy),
    .halted        (halted),
    .err_illegal   (err_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe vector: {rd, wr, load_w, load_a, compute}
  function automatic logic [31:0] strobes();
    return {27'd0, mem_rd_en, mem_wr_en, array_load_w, array_load_a, array_compute};
  endfunction

  // Reserved fields carry junk to prove they are ignored.
  function automatic logic [63:0] mk(input logic [3:0] op, input logic [15:0] base,
                                     input logic [15:0] len);
    return {op, 12'hABC, base, 16'h5A5A, len};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge while ready is high.
  task automatic send(input logic [63:0] word);
    instr_data  = word;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!instr_ready && n < budget) begin
      tick();
      n++;
    end
    check("wait_ready", {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst_ready",  {31'd0, instr_ready}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_err",    {31'd0, err_illegal}, 32'd0);
    check("rst_strb",   strobes(), 32'd0);
    check("rst_addr",   {16'd0, mem_addr}, 32'd0);

    // LOAD_W base 0x0100 L=4 presented continuously from reset release
    @(negedge clk);
    rst = 1'b1;
    instr_data  = mk(4'd1, 16'h0100, 16'd4);
    instr_valid = 1'b1;
    tick();
    check("ldw_ready_rise", {31'd0, instr_ready}, 32'd1);
    check("ldw_no_beat",    strobes(), 32'd0);
    tick();
    instr_valid = 1'b0;
    check("ldw_busy", {31'd0, busy}, 32'd1);
    check("ldw_ready_low", {31'd0, instr_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("ldw_strb", strobes(), 32'b10100);
      check("ldw_addr", {16'd0, mem_addr}, 32'h0100 + i);
      tick();
    end
    check("ldw_done_ready", {31'd0, instr_ready}, 32'd1);
    check("ldw_done_strb",  strobes(), 32'd0);
    check("ldw_done_busy",  {31'd0, busy}, 32'd0);

    // COMPUTE L=3: 3 beats + 15 drain cycles of array_compute
    send(mk(4'd3, 16'h0040, 16'd3));
    for (int i = 0; i < 18; i++) begin
      check("cmp_strb", strobes(), 32'b00001);
      check("cmp_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    check("cmp_end_strb", strobes(), 32'd0);
    check("cmp_end_busy", {31'd0, busy}, 32'd0);

    // STORE base 0xFFFE L=4 with a two-cycle stall after the 2nd beat
    send(mk(4'd4, 16'hFFFE, 16'd4));
    check("st_b1_strb", strobes(), 32'b01000);
    check("st_b1_addr", {16'd0, mem_addr}, 32'h0000FFFE);
    tick();
    check("st_b2_strb", strobes(), 32'b01000);
    check("st_b2_addr", {16'd0, mem_addr}, 32'h0000FFFF);
    tick();
    array_stall = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("st_stall_strb", strobes(), 32'd0);
      check("st_stall_addr", {16'd0, mem_addr}, 32'h0000);
      check("st_stall_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    array_stall = 1'b0;
    #1;
    check("st_b3_strb", strobes(), 32'b01000);
    check("st_b3_addr", {16'd0, mem_addr}, 32'h0000);
    tick();
    check("st_b4_strb", strobes(), 32'b01000);
    check("st_b4_addr", {16'd0, mem_addr}, 32'h0001);
    tick();
    check("st_done_strb",  strobes(), 32'd0);
    check("st_done_ready", {31'd0, instr_ready}, 32'd1);

    // Back-to-back: illegal 7, NOP, LOAD_A L=0, LOAD_A 0x10 L=1
    instr_valid = 1'b1;
    instr_data  = mk(4'd7, 16'h1234, 16'd5);
    tick();
    check("ill_err",   {31'd0, err_illegal}, 32'd1);
    check("ill_ready", {31'd0, instr_ready}, 32'd1);
    check("ill_strb",  strobes(), 32'd0);
    instr_data = mk(4'd0, 16'h2222, 16'd9);
    tick();
    check("nop_ready", {31'd0, instr_ready}, 32'd1);
    check("nop_busy",  {31'd0, busy}, 32'd0);
    instr_data = mk(4'd2, 16'h3333, 16'd0);
    tick();
    check("l0_ready", {31'd0, instr_ready}, 32'd1);
    check("l0_strb",  strobes(), 32'd0);
    instr_data = mk(4'd2, 16'h0010, 16'd1);
    tick();
    instr_valid = 1'b0;
    check("lda_strb", strobes(), 32'b10010);
    check("lda_addr", {16'd0, mem_addr}, 32'h0010);
    tick();
    check("lda_done_strb",  strobes(), 32'd0);
    check("lda_done_ready", {31'd0, instr_ready}, 32'd1);
    check("err_sticky",     {31'd0, err_illegal}, 32'd1);

    // HALT then a pending LOAD_W that must never be taken
    send(mk(4'd15, 16'h0000, 16'd0));
    check("halt_flag",  {31'd0, halted}, 32'd1);
    check("halt_ready", {31'd0, instr_ready}, 32'd0);
    instr_data  = mk(4'd1, 16'h0500, 16'd2);
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_hold_ready", {31'd0, instr_ready}, 32'd0);
      check("halt_hold_strb",  strobes(), 32'd0);
      check("halt_hold_flag",  {31'd0, halted}, 32'd1);
    end
    instr_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("halt_async_clr", {31'd0, halted}, 32'd0);
    check("err_async_clr",  {31'd0, err_illegal}, 32'd0);
    check("busy_async_clr", {31'd0, busy}, 32'd0);

    // Reset asserted during beat 2 of LOAD_W L=10
    @(negedge clk);
    rst = 1'b1;
    wait_ready(4);
    send(mk(4'd1, 16'h0200, 16'd10));
    tick();
    check("ab_b2_strb", strobes(), 32'b10100);
    check("ab_b2_addr", {16'd0, mem_addr}, 32'h0201);
    #2;
    rst = 1'b0;
    #1;
    check("ab_strb_drop", strobes(), 32'd0);
    check("ab_busy_drop", {31'd0, busy}, 32'd0);
    check("ab_addr_clr",  {16'd0, mem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("ab_ready", {31'd0, instr_ready}, 32'd1);
    check("ab_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    check("ab_no_replay", strobes(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
